// File: rtl/alu_operand_loader.sv
// alu_operand_loader: collects operand A, operand B and a function select from
// switches, one push-button press per item, presents them to an external
// combinational ALU for one cycle, captures its result and counts operations.
// Optional feature macro: ALU_LOADER_DEBOUNCE_EN (adds a stable-low debounce
// counter in front of the press detector). The default build has no debounce.
module alu_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw_in,
  input  logic [1:0] f_in,
  input  logic       load_n,
  input  logic [7:0] alu_result,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [1:0] f,
  output logic       valid,
  output logic [7:0] result,
  output logic [2:0] state,
  output logic [7:0] op_count
);

  typedef enum logic [2:0] {
    WAIT_A = 3'd0,
    WAIT_B = 3'd1,
    WAIT_F = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  // Synchronizer stages; vld_pN marks that sync_pN holds a real post-reset
  // sample rather than the released reset value, so a button already held
  // when reset drops never looks like a falling edge.
  logic sync_p0;
  logic sync_p1;
  logic vld_p0;
  logic vld_p1;
  logic press_p2;

  // Stage p0/p1: two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      sync_p0 <= load_n;
      sync_p1 <= sync_p0;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
    end
  end

`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] low_cnt;
  logic             armed;
  logic             low_now;

  assign low_now = vld_p1 & ~sync_p1;

  // Stage p2: count consecutive low samples; one press per low period, and
  // only once a genuine high level has been seen since reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      low_cnt  <= '0;
      armed    <= 1'b0;
      press_p2 <= 1'b0;
    end else begin
      press_p2 <= armed & low_now & (low_cnt == CNT_LAST);
      if (!low_now) begin
        low_cnt <= '0;
      end else if (low_cnt != CNT_SAT) begin
        low_cnt <= low_cnt + 1'b1;
      end
      if (vld_p1 && sync_p1) begin
        armed <= 1'b1;
      end else if (armed && low_now && (low_cnt == CNT_LAST)) begin
        armed <= 1'b0;
      end
    end
  end
`else
  logic sync_p2;
  logic unused_debounce_cfg;

  assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;

  // Stage p2: falling edge of the synchronized button becomes a one-cycle
  // press pulse; sync_p2 only remembers high levels that were real samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p2  <= 1'b0;
      press_p2 <= 1'b0;
    end else begin
      sync_p2  <= sync_p1 & vld_p1;
      press_p2 <= sync_p2 & ~sync_p1 & vld_p1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and valid decode; presses during EXEC are simply ignored.
  always_comb begin
    state_d = state_q;
    valid   = 1'b0;
    case (state_q)
      WAIT_A: if (press_p2) state_d = WAIT_B;
      WAIT_B: if (press_p2) state_d = WAIT_F;
      WAIT_F: if (press_p2) state_d = EXEC;
      EXEC: begin
        valid   = 1'b1;
        state_d = SHOW;
      end
      SHOW:   if (press_p2) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
  end

  // Operand, function, result and counter captures.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a        <= 4'd0;
      b        <= 4'd0;
      f        <= 2'd0;
      result   <= 8'd0;
      op_count <= 8'd0;
    end else begin
      case (state_q)
        WAIT_A: if (press_p2) a <= sw_in;
        WAIT_B: if (press_p2) b <= sw_in;
        WAIT_F: if (press_p2) f <= f_in;
        EXEC: begin
          result   <= alu_result;
          op_count <= op_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader (default build): drives button presses and
// switch values, tracks the expected operation at transaction level.
module tb_alu_operand_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw_in;
  logic [1:0] f_in;
  logic       load_n;
  logic [7:0] alu_result;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] f;
  logic       valid;
  logic [7:0] result;
  logic [2:0] state;
  logic [7:0] op_count;

  int errors = 0;
  int checks = 0;

  // Reference: phase holds the expected state code (0 A, 1 B, 2 F, 4 SHOW).
  int         m_phase;
  logic [3:0] m_a;
  logic [3:0] m_b;
  logic [1:0] m_f;
  logic [7:0] m_res;
  int         m_ops;

  alu_operand_loader #(.DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .sw_in(sw_in), .f_in(f_in), .load_n(load_n),
    .alu_result(alu_result), .a(a), .b(b), .f(f), .valid(valid),
    .result(result), .state(state), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_a = 4'd0;
    m_b = 4'd0;
    m_f = 2'd0;
    m_res = 8'd0;
    m_ops = 0;
  endtask

  task automatic check_all(input string ctx);
    check({ctx, "/state"}, 32'(state), 32'(m_phase));
    check({ctx, "/a"}, 32'(a), 32'(m_a));
    check({ctx, "/b"}, 32'(b), 32'(m_b));
    check({ctx, "/f"}, 32'(f), 32'(m_f));
    check({ctx, "/result"}, 32'(result), 32'(m_res));
    check({ctx, "/op_count"}, 32'(op_count), 32'(m_ops % 256));
  endtask

  // One button press: low for 'hold' cycles, then high for a settle window.
  task automatic press(input string ctx, input int hold);
    int vcount;
    int exp_v;
    vcount = 0;
    exp_v  = (m_phase == 2) ? 1 : 0;
    @(negedge clk);
    load_n = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (valid === 1'b1) vcount++;
    end
    load_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (valid === 1'b1) vcount++;
    end
    case (m_phase)
      0: begin m_a = sw_in; m_phase = 1; end
      1: begin m_b = sw_in; m_phase = 2; end
      2: begin m_f = f_in; m_res = alu_result; m_ops++; m_phase = 4; end
      default: m_phase = 0;
    endcase
    check({ctx, "/valid_pulses"}, 32'(vcount), 32'(exp_v));
    check_all(ctx);
  endtask

  // Switch activity with no press must leave every output untouched.
  task automatic wiggle(input string ctx, input int n);
    repeat (n) begin
      @(negedge clk);
      sw_in = 4'($urandom);
      f_in  = 2'($urandom);
      alu_result = 8'($urandom);
    end
    @(negedge clk);
    check({ctx, "/valid_idle"}, 32'(valid), 32'd0);
    check_all(ctx);
  endtask

  task automatic full_op(input string ctx);
    sw_in = 4'($urandom);
    press(ctx, $urandom_range(4, 8));
    if ($urandom_range(0, 3) == 0) wiggle({ctx, "/wig"}, 2);
    sw_in = 4'($urandom);
    press(ctx, $urandom_range(4, 8));
    f_in = 2'($urandom);
    alu_result = 8'($urandom);
    press(ctx, $urandom_range(4, 8));
  endtask

  initial begin
    reset = 1'b1;
    load_n = 1'b1;
    sw_in = 4'd0;
    f_in = 2'd0;
    alu_result = 8'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset/valid", 32'(valid), 32'd0);
    check_all("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Directed operation: 3, 5, function 00, ALU answers 08.
    sw_in = 4'd3;
    press("op1_a", 6);
    sw_in = 4'd5;
    press("op1_b", 6);
    f_in = 2'd0;
    alu_result = 8'h08;
    press("op1_f", 6);
    check("op1/a", 32'(a), 32'd3);
    check("op1/b", 32'(b), 32'd5);
    check("op1/result", 32'(result), 32'h08);
    check("op1/op_count", 32'(op_count), 32'd1);
    check("op1/state", 32'(state), 32'd4);
    wiggle("show_hold", 4);
    press("op1_ret", 5);

    // Switch changes in WAIT_B without a press are ignored.
    sw_in = 4'd7;
    press("op2_a", 5);
    @(negedge clk); sw_in = 4'h0;
    @(negedge clk); sw_in = 4'hF;
    @(negedge clk); sw_in = 4'h2;
    @(negedge clk);
    check_all("waitb_idle");
    press("op2_b", 5);
    check("op2/b", 32'(b), 32'd2);
    check("op2/a", 32'(a), 32'd7);
    f_in = 2'd3;
    alu_result = 8'hA5;
    press("op2_f", 5);
    press("op2_ret", 5);

    // Long hold gives exactly one step.
    sw_in = 4'd6;
    press("hold50", 50);
    check("hold50/state", 32'(state), 32'd1);

    // Asynchronous reset in WAIT_F with a=9, b=7.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    @(negedge clk);
    sw_in = 4'd9;
    press("rst_a", 5);
    sw_in = 4'd7;
    press("rst_b", 5);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("midrst/valid", 32'(valid), 32'd0);
    check_all("midrst");
    @(negedge clk);
    check_all("midrst_hold");

    // Button held through reset release generates no press.
    load_n = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (20) @(negedge clk);
    check_all("held_release");
    load_n = 1'b1;
    repeat (6) @(negedge clk);
    check_all("held_up");
    sw_in = 4'd4;
    press("after_held", 5);

    // Randomized operations through op_count wrap.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    @(negedge clk);
    for (int i = 1; i <= 257; i++) begin
      full_op("rand");
      if (i == 256) check("wrap256/op_count", 32'(op_count), 32'd0);
      if (i == 257) check("wrap257/op_count", 32'(op_count), 32'd1);
      press("rand_ret", $urandom_range(4, 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
